// File: rtl/constraint_eval_pipe.sv
// Streaming constraint evaluator: per-channel predicates, AND/OR combine, 2-stage valid/ready pipe,
// per-batch satisfying-beat counter. Optional first-hit tracking under CONSTRAINT_FIRST_HIT_EN.
module constraint_eval_pipe #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NCH*W-1:0]   in_data,
  input  logic               in_last,
  input  logic [2*NCH-1:0]   cfg_mode,
  input  logic               cfg_combine,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_x,
  output logic [CNT_W-1:0]   sat_count,
  output logic               done
`ifdef CONSTRAINT_FIRST_HIT_EN
  ,
  output logic               first_hit_vld,
  output logic [CNT_W-1:0]   first_hit_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [2*NCH-1:0] mode_q;
  logic             comb_q;
  logic [2*NCH-1:0] mode_eff;
  logic             comb_eff;
  logic [NCH-1:0]   pred;

  logic             s1_v, s1_last, s2_v, s2_last;
  logic [NCH-1:0]   s1_p;
  logic             adv1, adv2, accept, start, out_hs;

  assign adv2      = ~s2_v | out_ready;
  assign adv1      = ~s1_v | adv2;
  assign in_ready  = ~rst & adv1 & (state != DONE);
  assign accept    = in_valid & in_ready;
  assign start     = accept & (state == IDLE);
  assign out_hs    = s2_v & out_ready;
  assign out_valid = s2_v;

  // The first beat of a batch is evaluated with the live config, which is latched on the same edge.
  assign mode_eff = (state == IDLE) ? cfg_mode : mode_q;
  assign comb_eff = (state == IDLE) ? cfg_combine : comb_q;

  always_comb begin
    pred = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      case (mode_eff[2*k +: 2])
        2'b00:   pred[k] = ~|in_data[k*W +: W];
        2'b01:   pred[k] = |in_data[k*W +: W];
        2'b10:   pred[k] = &in_data[k*W +: W];
        default: pred[k] = ~comb_eff;  // neutral element of the chosen combine
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = in_last ? DONE : RUN;
      RUN:     if (accept && in_last) state_nx = DONE;
      DONE:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      done   <= 1'b0;
      mode_q <= '0;
      comb_q <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= (state == DONE) & out_hs & s2_last;
      if (start) begin
        mode_q <= cfg_mode;
        comb_q <= cfg_combine;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_p    <= '0;
      s1_last <= 1'b0;
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      out_x   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_v    <= accept;
        s1_p    <= pred;
        s1_last <= in_last;
      end
      if (adv2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          out_x   <= comb_q ? |s1_p : &s1_p;
          s2_last <= s1_last;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start)
      sat_count <= '0;
    else if (out_hs && out_x && sat_count != '1)
      sat_count <= sat_count + CNT_W'(1);
  end

`ifdef CONSTRAINT_FIRST_HIT_EN
  logic [CNT_W-1:0] out_idx;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      out_idx       <= '0;
      first_hit_vld <= 1'b0;
      first_hit_idx <= '0;
    end else if (out_hs) begin
      if (out_x && !first_hit_vld) begin
        first_hit_vld <= 1'b1;
        first_hit_idx <= out_idx;
      end
      if (out_idx != '1) out_idx <= out_idx + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_constraint_eval_pipe.sv
// Randomized bench for constraint_eval_pipe against a transaction-level reference model.
// Define CONSTRAINT_FIRST_HIT_EN on both files to exercise the first-hit outputs.
module tb_constraint_eval_pipe;
  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, in_last, cfg_combine;
  logic               out_valid, out_ready, out_x, done;
  logic [NCH*W-1:0]   in_data;
  logic [2*NCH-1:0]   cfg_mode;
  logic [CNT_W-1:0]   sat_count;
`ifdef CONSTRAINT_FIRST_HIT_EN
  logic               first_hit_vld;
  logic [CNT_W-1:0]   first_hit_idx;
`endif

  constraint_eval_pipe #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .cfg_mode(cfg_mode), .cfg_combine(cfg_combine),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .sat_count(sat_count), .done(done)
`ifdef CONSTRAINT_FIRST_HIT_EN
    , .first_hit_vld(first_hit_vld), .first_hit_idx(first_hit_idx)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a beat satisfies AND if every non-don't-care channel holds,
  // OR if at least one non-don't-care channel holds.
  function automatic bit model_x(input logic [31:0] d, input logic [7:0] md, input bit cb);
    int care = 0;
    int hits = 0;
    for (int k = 0; k < NCH; k++) begin
      logic [7:0] op;
      logic [1:0] m;
      op = d[k*8 +: 8];
      m  = md[k*2 +: 2];
      if (m != 2'd3) begin
        care++;
        if ((m == 2'd0 && op == 8'h00) || (m == 2'd1 && op != 8'h00) || (m == 2'd2 && op == 8'hFF))
          hits++;
      end
    end
    return cb ? (hits > 0) : (hits == care);
  endfunction

  typedef struct { bit x; bit last; int acc; } item_t;
  item_t      q[$];
  int         cyc = 0;
  int         cnt = 0;
  bit         closed = 0, need_cfg = 1, done_pending = 0;
  logic [7:0] lat_mode;
  bit         lat_comb;
`ifdef CONSTRAINT_FIRST_HIT_EN
  int         hs_idx = 0;
  bit         fh_vld = 0;
  int         fh_idx = 0;
`endif

  logic [31:0] beat_buf[$];

  task automatic step(input bit r, input bit iv, input logic [31:0] d, input bit lst,
                      input logic [7:0] md, input bit cb, input bit ordy, output bit acc);
    bit exp_ir, exp_ov, exp_done;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; in_last = lst;
    cfg_mode = md; cfg_combine = cb; out_ready = ordy;
    #1;
    acc = 0;
    if (r) begin
      check("rst_in_ready", int'(in_ready), 0);
      q.delete();
      cnt = 0; closed = 0; need_cfg = 1; done_pending = 0;
`ifdef CONSTRAINT_FIRST_HIT_EN
      hs_idx = 0; fh_vld = 0; fh_idx = 0;
`endif
    end else begin
      exp_done     = done_pending;
      done_pending = 0;
      exp_ir = !closed && !(q.size() == 2 && !ordy);
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
      check("in_ready", int'(in_ready), int'(exp_ir));
      check("out_valid", int'(out_valid), int'(exp_ov));
      if (exp_ov) check("out_x", int'(out_x), int'(q[0].x));
      check("sat_count", int'(sat_count), cnt);
      check("done", int'(done), int'(exp_done));
`ifdef CONSTRAINT_FIRST_HIT_EN
      check("first_hit_vld", int'(first_hit_vld), int'(fh_vld));
      if (fh_vld) check("first_hit_idx", int'(first_hit_idx), fh_idx);
`endif
      if (exp_done) closed = 0;
      if (exp_ov && ordy) begin
        item_t it;
        it = q.pop_front();
        if (it.x && cnt < SAT) cnt++;
`ifdef CONSTRAINT_FIRST_HIT_EN
        if (it.x && !fh_vld) begin
          fh_vld = 1;
          fh_idx = (hs_idx < SAT) ? hs_idx : SAT;
        end
        hs_idx++;
`endif
        if (it.last) done_pending = 1;
      end
      if (iv && exp_ir) begin
        acc = 1;
        if (need_cfg) begin
          lat_mode = md; lat_comb = cb; need_cfg = 0; cnt = 0;
`ifdef CONSTRAINT_FIRST_HIT_EN
          hs_idx = 0; fh_vld = 0; fh_idx = 0;
`endif
        end
        q.push_back('{x: model_x(d, lat_mode, lat_comb), last: lst, acc: cyc});
        if (lst) begin
          closed = 1; need_cfg = 1;
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] rand_beat();
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < NCH; k++) begin
      case ($urandom_range(0, 3))
        0:       b[k*8 +: 8] = 8'h00;
        1:       b[k*8 +: 8] = 8'hFF;
        default: b[k*8 +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return b;
  endfunction

  // Streams beat_buf[0..n-1] as one batch; config is only meaningful on the first beat,
  // other cycles present random config to show mid-batch changes are ignored.
  task automatic run_batch(input int n, input logic [7:0] md, input bit cb, input int iv_pct,
                           input int or_pct, input int st_start, input int st_len,
                           input int abort_after);
    int  idx = 0;
    int  guard = 0;
    bit  acc, iv, ordy;
    while (guard < 600) begin
      if (abort_after >= 0 && idx == abort_after) begin
        step(1, 0, '0, 0, '0, 0, 1, acc);
        return;
      end
      iv   = (idx < n) && ($urandom_range(0, 99) < iv_pct);
      ordy = !(guard >= st_start && guard < st_start + st_len) && ($urandom_range(0, 99) < or_pct);
      step(0, iv, beat_buf[(idx < n) ? idx : 0], idx == n - 1,
           (idx == 0) ? md : 8'($urandom), (idx == 0) ? cb : 1'($urandom), ordy, acc);
      if (acc) idx++;
      if (idx == n && !closed && q.size() == 0 && !done_pending) break;
      guard++;
    end
    check("batch_timeout", int'(guard < 600), 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0, 1, acc);
  endtask

  initial begin
    bit acc;
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; cfg_mode = '0; cfg_combine = 0; out_ready = 0;
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, '0, 0, 0, acc);
    idle(2);

    // all ZERO, AND: x = 1,0,1
    beat_buf = '{32'h0, 32'h0000_0100, 32'h0};
    run_batch(3, 8'h00, 0, 100, 100, 0, 0, -1);
    check("t1_sat", int'(sat_count), 2);

    // {NONZERO,ALLONES,DC,DC}: OR satisfied, AND not
    beat_buf = '{32'h3412_FF00};
    run_batch(1, 8'hF9, 1, 100, 100, 0, 0, -1);
    check("t2_or_sat", int'(sat_count), 1);
    run_batch(1, 8'hF9, 0, 100, 100, 0, 0, -1);
    check("t2_and_sat", int'(sat_count), 0);

    // all DONTCARE under OR never satisfies
    beat_buf = '{rand_beat(), rand_beat()};
    run_batch(2, 8'hFF, 1, 100, 100, 0, 0, -1);
    check("all_dc_or_sat", int'(sat_count), 0);

    // backpressure burst during a 4-beat stream
    beat_buf = '{rand_beat(), rand_beat(), rand_beat(), rand_beat()};
    run_batch(4, 8'($urandom), 1'($urandom), 100, 100, 1, 5, -1);

    // counter saturation
    beat_buf.delete();
    for (int i = 0; i < 20; i++) beat_buf.push_back(32'h0);
    run_batch(20, 8'h00, 0, 100, 100, 0, 0, -1);
    check("sat_stick", int'(sat_count), SAT);

    // reset mid-batch, then a clean batch
    beat_buf = '{32'h0, 32'h0, 32'h0, 32'h0};
    run_batch(4, 8'h00, 0, 100, 0, 0, 0, 2);
    idle(3);
    check("rst_sat", int'(sat_count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    beat_buf = '{32'h0, 32'h0000_0100, 32'h0};
    run_batch(3, 8'h00, 0, 100, 100, 0, 0, -1);
    check("post_rst_sat", int'(sat_count), 2);

    // x sequence 0,0,1,1
    beat_buf = '{32'h1, 32'h1, 32'h0, 32'h0};
    run_batch(4, 8'h00, 0, 100, 100, 0, 0, -1);
`ifdef CONSTRAINT_FIRST_HIT_EN
    check("fh_vld", int'(first_hit_vld), 1);
    check("fh_idx", int'(first_hit_idx), 2);
`endif
    check("fh_seq_sat", int'(sat_count), 2);

    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(1, 8);
      beat_buf.delete();
      for (int i = 0; i < n; i++) beat_buf.push_back(rand_beat());
      run_batch(n, 8'($urandom), 1'($urandom), $urandom_range(60, 100), $urandom_range(30, 100),
                $urandom_range(0, 4), $urandom_range(0, 4), -1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
